seq_controller_p: RTL and testbench
===================================

Name: seq_controller_p

Overview:
- Parameterised next-generation 8-phase sequence controller for the accumulator CPU.
- Decodes opcode and ALU zero flag into memory, IR, PC and AC control strobes.
- Adds a memory wait handshake, a sticky HALTED state with a resume input, a phase output and an optional extended 4-bit opcode set.
- Sits between the instruction register / ALU and the memory, PC and accumulator registers.

Parameters:
OPW, 3, opcode width; legal values 3 or 4. 4 enables the extended opcodes.
CNT_W, 16, width of the retired-instruction counter (optional feature).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_  input  1  synchronous reset, active-high (1 = reset)
opcode  input  OPW  current IR opcode field
zero  input  1  accumulator-zero flag
mem_ready  input  1  memory done; qualifies memory phases
resume  input  1  leave HALTED (level-sampled)
mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr  output  1 each  control strobes
phase  output  3  current phase, 0..7
illegal  output  1  unmapped opcode decoded (OPW=4 only)
icount  output  CNT_W  retired-instruction count

Behaviour:
- Phase register encodings: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Separate registered halted flag.
- Reset (rst_=1 at an edge): phase=0, halted=0, icount=0. All strobes are then 0.
- Strobes are combinational from phase, halted, opcode and zero; they change no later than the cycle after the phase changes.
- Opcodes for OPW=3, and the low 3 bits when the MSB is 0: HLT 000, SKZ 001, ADD 010, AND 011, XOR 100, LDA 101, STO 110, JMP 111.
  - ALUOP = ADD|AND|XOR|LDA.
- Extended opcodes, OPW=4 with MSB 1:
  - 1000 SKNZ: skip if zero=0.
  - 1001 JZ: load_pc if zero=1.
  - 1010 NOP.
  - 1011..1111: illegal=1 during phases 4-7 and behaves as HLT.
- Strobe table, not halted:
  - Phase 0: none.
  - Phase 1: mem_rd.
  - Phase 2: mem_rd, load_ir.
  - Phase 3: mem_rd, load_ir.
  - Phase 4: inc_pc; halt=(HLT or illegal).
  - Phase 5: mem_rd=ALUOP.
  - Phase 6: mem_rd=ALUOP; inc_pc=(SKZ&zero | SKNZ&!zero); load_pc=(JMP | JZ&zero).
  - Phase 7: mem_rd=ALUOP, load_ac=ALUOP, load_pc=(JMP | JZ&zero), mem_wr=STO.
- Phase advance:
  - phase increments mod 8 each cycle, wrapping 7->0.
  - Exception: in phases 1, 5, 7, when mem_rd|mem_wr is asserted and mem_ready=0, phase holds and all strobes hold their values.
  - Phases with no memory strobe ignore mem_ready.
- HALTED:
  - Entered at the end of phase 4 when halt=1. halted is set and phase stays 4.
  - While halted: halt=1, all other strobes 0, mem_ready ignored. inc_pc therefore pulses only once per HLT.
  - resume=1 sampled while halted: clear halted; next phase=5.
  - resume sampled while not halted has no effect.
  - resume on the same edge that enters HALTED is ignored; at least one halted cycle always occurs.
- Reset overrides everything, including mid-wait and mid-halt.
- icount increments by 1 on every edge where phase 7 completes (7->0 with no wait). It wraps modulo 2^CNT_W.
- opcode and zero must be stable from phase 3 to phase 7. The controller does not latch them.

Optional Feature:
- Macro: SEQ_ICOUNT_EN.
- Defined: icount counter is implemented as above.
- Undefined: no counter register; icount is tied to 0. All other behaviour is identical.

Test Plan:
- Reset, then ADD (010), zero=0, mem_ready=1 for 16 cycles:
  - phase runs 0..7,0..7.
  - mem_rd high in phases 1,2,3,5,6,7; load_ir in 2,3; inc_pc in 4; load_ac in 7.
  - icount=2.
- HLT (000), resume=0 for 10 cycles:
  - halt=1 from phase 4 onward; inc_pc high exactly 1 cycle; phase frozen at 4.
  - Pulse resume=1 for one cycle: next phase 5, then 6, 7, 0; halt=0 after exit.
- SKZ (001) with zero=1: inc_pc high in phases 4 and 6. With zero=0: inc_pc high in phase 4 only. load_pc never asserted.
- JMP (111): load_pc in phases 6 and 7, mem_wr=0. STO (110): mem_wr only in phase 7, mem_rd=0 in phases 5-7.
- LDA (101), mem_ready=0 for 3 cycles on entering phase 5:
  - phase holds at 5 for 4 cycles with mem_rd=1, then advances.
  - Assert rst_=1 mid-wait: next cycle phase=0, all strobes 0, icount=0.
- OPW=4:
  - JZ (1001), zero=1: load_pc in phases 6 and 7.
  - 1100: illegal=1 in phase 4, HALTED entered.
  - SKNZ (1000), zero=0: inc_pc in phase 6.

Source files
------------

// File: rtl/seq_controller_p.sv
// rtl/seq_controller_p.sv - 8-phase accumulator CPU sequence controller with memory wait, HALTED state and optional extended opcodes
// Optional retired-instruction counter enabled by macro SEQ_ICOUNT_EN; otherwise icount is tied to 0.
module seq_controller_p #(
    parameter int OPW   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [OPW-1:0]   opcode,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             mem_rd,
    output logic             load_ir,
    output logic             halt,
    output logic             inc_pc,
    output logic             load_ac,
    output logic             load_pc,
    output logic             mem_wr,
    output logic [2:0]       phase,
    output logic             illegal,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t     r_phase;
    logic       r_halted;
    logic       w_ext;
    logic [2:0] w_lo;
    logic       w_hlt, w_skz, w_aluop, w_sto, w_jmp, w_sknz, w_jz, w_ill;
    logic       w_stall;

    // Extended opcodes exist only for the 4-bit build, selected by the opcode MSB.
    generate
        if (OPW == 4) begin : g_ext
            assign w_ext = opcode[OPW-1];
        end else begin : g_noext
            assign w_ext = 1'b0;
        end
    endgenerate

    assign w_lo = opcode[2:0];

    always_comb begin
        w_hlt   = !w_ext && (w_lo == 3'b000);
        w_skz   = !w_ext && (w_lo == 3'b001);
        w_aluop = !w_ext && (w_lo inside {3'b010, 3'b011, 3'b100, 3'b101});
        w_sto   = !w_ext && (w_lo == 3'b110);
        w_jmp   = !w_ext && (w_lo == 3'b111);
        w_sknz  =  w_ext && (w_lo == 3'b000);
        w_jz    =  w_ext && (w_lo == 3'b001);
        w_ill   =  w_ext && (w_lo >= 3'b011);
    end

    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        illegal = w_ill && r_phase[2];
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            case (r_phase)
                INST_ADDR:  ;
                INST_FETCH: mem_rd = 1'b1;
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = w_hlt || w_ill;
                end
                OP_FETCH: mem_rd = w_aluop;
                ALU_OP: begin
                    mem_rd  = w_aluop;
                    inc_pc  = (w_skz && zero) || (w_sknz && !zero);
                    load_pc = w_jmp || (w_jz && zero);
                end
                STORE: begin
                    mem_rd  = w_aluop;
                    load_ac = w_aluop;
                    load_pc = w_jmp || (w_jz && zero);
                    mem_wr  = w_sto;
                end
                default: ;
            endcase
        end
    end

    // Only the memory-owning phases wait; strobes hold because phase and inputs hold.
    assign w_stall = (r_phase inside {INST_FETCH, OP_FETCH, STORE}) &&
                     (mem_rd || mem_wr) && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else if (r_halted) begin
            if (resume) begin
                r_halted <= 1'b0;
                r_phase  <= OP_FETCH;
            end
        end else if (r_phase == OP_ADDR && halt) begin
            r_halted <= 1'b1;
        end else if (!w_stall) begin
            r_phase <= phase_t'(r_phase + 3'd1);
        end
    end

    assign phase = r_phase;

`ifdef SEQ_ICOUNT_EN
    logic [CNT_W-1:0] r_icount;

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_icount <= '0;
        end else if (!r_halted && r_phase == STORE && !w_stall) begin
            r_icount <= r_icount + CNT_W'(1);
        end
    end

    assign icount = r_icount;
`else
    assign icount = '0;
`endif

endmodule

// File: tb/tb_seq_controller_p.sv
// tb/tb_seq_controller_p.sv - randomized bench for seq_controller_p (3-bit and 4-bit opcode builds) against a behavioural model
module tb_seq_controller_p;

    logic       clk = 1'b0;
    logic       rst_ = 1'b1;
    logic       mem_ready = 1'b1;
    logic       resume = 1'b0;
    logic [2:0] op3 = '0;
    logic [3:0] op4 = '0;
    logic       z3 = 1'b0, z4 = 1'b0;

    logic        a_rd, a_ir, a_hlt, a_inc, a_ac, a_pc, a_wr, a_ill;
    logic        b_rd, b_ir, b_hlt, b_inc, b_ac, b_pc, b_wr, b_ill;
    logic [2:0]  a_ph, b_ph;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int m_ph[2], m_cnt[2], m_op[2];
    bit m_hl[2], m_z[2];

    always #5 clk = ~clk;

    seq_controller_p #(.OPW(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst_(rst_), .opcode(op3), .zero(z3), .mem_ready(mem_ready), .resume(resume),
        .mem_rd(a_rd), .load_ir(a_ir), .halt(a_hlt), .inc_pc(a_inc), .load_ac(a_ac),
        .load_pc(a_pc), .mem_wr(a_wr), .phase(a_ph), .illegal(a_ill), .icount(a_cnt)
    );

    seq_controller_p #(.OPW(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_(rst_), .opcode(op4), .zero(z4), .mem_ready(mem_ready), .resume(resume),
        .mem_rd(b_rd), .load_ir(b_ir), .halt(b_hlt), .inc_pc(b_inc), .load_ac(b_ac),
        .load_pc(b_pc), .mem_wr(b_wr), .phase(b_ph), .illegal(b_ill), .icount(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bit order: {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, illegal}
    function automatic logic [7:0] model_strobes(input int ph, input bit hl, input int op,
                                                 input bit ext_ok, input bit z);
        bit ext  = ext_ok && (op >= 8);
        int lo   = op % 8;
        bit hlt  = !ext && lo == 0;
        bit skz  = !ext && lo == 1;
        bit alu  = !ext && lo >= 2 && lo <= 5;
        bit sto  = !ext && lo == 6;
        bit jmp  = !ext && lo == 7;
        bit sknz = ext && lo == 0;
        bit jz   = ext && lo == 1;
        bit ill  = ext && lo >= 3;
        bit rd = 0, ir = 0, h = 0, inc = 0, ac = 0, pc = 0, wr = 0;
        if (hl) h = 1;
        else if (ph == 1) rd = 1;
        else if (ph == 2 || ph == 3) begin rd = 1; ir = 1; end
        else if (ph == 4) begin inc = 1; h = hlt || ill; end
        else if (ph == 5) rd = alu;
        else if (ph == 6) begin
            rd = alu; inc = (skz && z) || (sknz && !z); pc = jmp || (jz && z);
        end else if (ph == 7) begin
            rd = alu; ac = alu; pc = jmp || (jz && z); wr = sto;
        end
        return {rd, ir, h, inc, ac, pc, wr, ill && ph >= 4};
    endfunction

    initial begin
        logic [7:0] e;
        logic [7:0] obs;
        int exp_cnt;
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_hl[i] = 0; m_cnt[i] = 0; m_op[i] = 0; m_z[i] = 0;
        end
        @(posedge clk);
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            rst_      = (cyc < 2) || ($urandom_range(0, 99) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            resume    = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!m_hl[i] && m_ph[i] <= 2) begin
                    m_z[i] = 1'($urandom_range(0, 1));
                    if (m_ph[i] == 0) m_op[i] = (i == 0) ? $urandom_range(0, 7) : $urandom_range(0, 15);
                end
            end
            op3 = 3'(m_op[0]); z3 = m_z[0];
            op4 = 4'(m_op[1]); z4 = m_z[1];
            #1;
            for (int i = 0; i < 2; i++) begin
                e = model_strobes(m_ph[i], m_hl[i], m_op[i], i == 1, m_z[i]);
`ifdef SEQ_ICOUNT_EN
                exp_cnt = (i == 0) ? (m_cnt[i] % 65536) : (m_cnt[i] % 16);
`else
                exp_cnt = 0;
`endif
                if (i == 0) begin
                    obs = {a_rd, a_ir, a_hlt, a_inc, a_ac, a_pc, a_wr, a_ill};
                    check("opw3.strobes", 32'(obs), 32'(e));
                    check("opw3.phase", 32'(a_ph), 32'(m_ph[i]));
                    check("opw3.icount", 32'(a_cnt), 32'(exp_cnt));
                end else begin
                    obs = {b_rd, b_ir, b_hlt, b_inc, b_ac, b_pc, b_wr, b_ill};
                    check("opw4.strobes", 32'(obs), 32'(e));
                    check("opw4.phase", 32'(b_ph), 32'(m_ph[i]));
                    check("opw4.icount", 32'(b_cnt), 32'(exp_cnt));
                end
                // Next-state of the model for the coming rising edge
                if (rst_) begin
                    m_ph[i] = 0; m_hl[i] = 0; m_cnt[i] = 0;
                end else if (m_hl[i]) begin
                    if (resume) begin m_hl[i] = 0; m_ph[i] = 5; end
                end else if (m_ph[i] == 4 && e[5]) begin
                    m_hl[i] = 1;
                end else if ((m_ph[i] == 1 || m_ph[i] == 5 || m_ph[i] == 7) &&
                             (e[7] || e[1]) && !mem_ready) begin
                    m_ph[i] = m_ph[i];
                end else begin
                    if (m_ph[i] == 7) m_cnt[i]++;
                    m_ph[i] = (m_ph[i] + 1) % 8;
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
